aes_key_schedule_iter: RTL and testbench
========================================

// Module: aes_key_schedule_iter
// PURPOSE
// Iterative AES key schedule for AES-128/192/256, with key length selectable per job at run time.
// Produces one 32-bit schedule word per cycle and emits round keys RK0..RKNr as 128-bit beats on a valid/ready stream.
// Replaces the fixed 128-bit, single-round expander. Feeds the round pipeline of the AES encrypt core.
// PARAMETERS
// MAX_KEY_BITS  256  largest key supported (128|192|256); sets window depth MAX_NK = MAX_KEY_BITS/32
// RK_IDX_W      4    width of rk_idx (must hold 14)
// PORTS
// clk       input   1         clock, rising edge
// rst       input   1         asynchronous reset, active-low
// start     input   1         job request; sampled only when busy=0
// key_len   input   2         00=128, 01=192, 10=256, 11=illegal; sampled with start
// key_in    input   256       key, MSB-aligned; w0=key_in[255:224]; unused LSBs ignored
// abort     input   1         cancel current job
// rk_data   output  128       round key; word w[4r] in [127:96]
// rk_valid  output  1         rk_data/rk_idx/rk_last valid
// rk_ready  input   1         consumer accepts beat when rk_valid&rk_ready
// rk_idx    output  RK_IDX_W  round index r of current beat
// rk_last   output  1         beat is RKNr (Nr=10/12/14)
// busy      output  1         job in progress
// done      output  1         one-cycle pulse after final beat accepted
// key_err   output  1         one-cycle pulse: start rejected
// BEHAVIOUR
// - Reset (rst=0, async): all outputs 0, FSM=IDLE, Rcon=01, word counter=0.
// - FSM: IDLE -> RUN on legal start; RUN -> DRAIN when word 4(Nr+1)-1 is produced; DRAIN -> IDLE on last handshake.
// - start rules: legal start in IDLE latches key and Nk (4/6/8) and sets busy on the next edge.
//   key_len=11, or a key longer than MAX_KEY_BITS: start ignored, key_err=1 for one cycle, busy stays 0.
//   start while busy=1: ignored, no key_err.
// - Words: w0..w(Nk-1) = key words. For i>=Nk: w[i] = w[i-Nk] ^ t, where
//   t = SubWord(RotWord(w[i-1]))^{Rcon,24'h0} if i%Nk==0 (Rcon then doubles in GF(2^8): 01,02,..,80,1b,36);
//   t = SubWord(w[i-1]) if Nk==8 && i%Nk==4;
//   t = w[i-1] otherwise.
// - Window: shift register of the last Nk words, MAX_NK deep; 4 S-box instances, combinational.
// - Rate: one word per edge while RUN and not stalled. Accumulator collects 4 words, then moves to the rk_data register.
// - Latency: start at edge E0 -> rk_valid=1 with RK0 after E4. With rk_ready=1 held, RKr is valid after E(4r+4).
//   AES-128 last beat after E44, AES-192 after E52, AES-256 after E60.
// - Stall: generation halts while the accumulator is full and rk_valid&!rk_ready. No word is lost or duplicated.
// - rk_data, rk_idx and rk_last are stable while rk_valid&!rk_ready. rk_idx increments by 1 per beat, from 0.
// - done=1 on the edge after the RKNr handshake; busy drops on the same edge. A start in that same cycle is ignored.
// - abort=1 while busy: next edge -> IDLE, rk_valid=0, busy=0, no done. Abort in IDLE has no effect.
//   Abort beats start if both are asserted.
// - Reset asserted mid-job: immediate return to reset state; the partial job is discarded.
// CONFIGURATION
// AES_KS_ZEROIZE_EN defined:
//   - key, window, accumulator and rk_data are cleared to 0 on the edge that ends a job (last handshake or abort).
//   - rk_data=0 whenever rk_valid=0.
// AES_KS_ZEROIZE_EN undefined: these registers keep their last values. Stream behaviour is identical.
// TESTING
// 1 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> RK0=key, RK1=a0fafe1788542cb123a339392a6c7605,
//   RK10=d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1; done 1 cycle later.
// 2 AES-192, key 000102..1617 -> 13 beats; RK12=a4970a331a78dc09c418c271e3a41d5d, rk_idx=12, rk_last=1.
// 3 AES-256, key 000102..1e1f -> 15 beats; RK14=24fc79ccbf0979e9371ac23c6d68de36, rk_last=1.
// 4 Test 1 with random rk_ready (~40% low) -> same 11 keys in order; rk_data stable during every stall.
// 5 key_len=11 -> key_err pulse, busy=0. start while busy -> ignored. abort after RK3 -> no done, busy=0 next cycle.
//   A new AES-128 job then gives correct RK0..RK10.
// 6 rst=0 mid-job (async, between edges) -> all outputs 0 immediately.
//   With AES_KS_ZEROIZE_EN: rk_data=0 after done.

Source files
------------

// File: rtl/aes_key_schedule_iter.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per cycle, round keys out as 128-bit valid/ready beats.
// Optional AES_KS_ZEROIZE_EN clears key material at job end and holds rk_data at 0 whenever rk_valid is low.
module aes_key_schedule_iter #(
   parameter int MAX_KEY_BITS = 256,
   parameter int RK_IDX_W     = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [1:0]          key_len,
   input  logic [255:0]        key_in,
   input  logic                abort,
   output logic [127:0]        rk_data,
   output logic                rk_valid,
   input  logic                rk_ready,
   output logic [RK_IDX_W-1:0] rk_idx,
   output logic                rk_last,
   output logic                busy,
   output logic                done,
   output logic                key_err
);

   localparam int MAX_NK = MAX_KEY_BITS / 32;
   localparam int IDX_W  = $clog2(MAX_NK);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Inverse as x^254 (bits 1..7 of the exponent set), then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv, base;
      inv  = 8'h01;
      base = x;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) inv = gf_mul(inv, base);
         base = gf_mul(base, base);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   state_t           state, state_nxt;
   logic [255:0]     key_q;
   logic [IDX_W-1:0] nk_m1, pos, req_nk_m1;
   logic [5:0]       word_cnt, last_word;
   logic [7:0]       rcon;
   logic [31:0]      win [MAX_NK];
   logic [31:0]      key_w [MAX_NK];
   logic [31:0]      acc0, acc1, acc2;
   logic [31:0]      prev, sub_in, sub_out, t_word, new_word;
   logic [1:0]       slot;
   int               req_nk;
   logic             req_illegal, start_ok, start_bad, hs, gen_en, is_key, job_end;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
      req_nk    = 4;
      req_nk_m1 = IDX_W'(3);
      case (key_len)
         2'b01:   begin req_nk = 6; req_nk_m1 = IDX_W'(5); end
         2'b10:   begin req_nk = 8; req_nk_m1 = IDX_W'(7); end
         default: ;
      endcase
      req_illegal = (key_len == 2'b11) || (req_nk > MAX_NK);
      for (int k = 0; k < MAX_NK; k++) key_w[k] = key_q[255 - 32*k -: 32];
   end

   assign start_ok  = start && (state == IDLE) && !done && !abort && !req_illegal;
   assign start_bad = start && (state == IDLE) && !done && !abort && req_illegal;
   assign hs        = rk_valid && rk_ready;
   assign slot      = word_cnt[1:0];
   // The fourth word of a group goes straight into rk_data, so it needs the output register free.
   assign gen_en    = (state == RUN) && !abort && ((slot != 2'd3) || !rk_valid || rk_ready);
   assign last_word = 6'({nk_m1, 2'b00}) + 6'd31;
   assign is_key    = (word_cnt <= 6'(nk_m1));
   assign job_end   = (state != IDLE) && (abort || ((state == DRAIN) && hs));

   assign prev   = win[0];
   assign sub_in = (pos == '0) ? {prev[23:0], prev[31:24]} : prev;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      assign sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
   end

   always_comb begin
      t_word = prev;
      if (pos == '0)                                  t_word = sub_out ^ {rcon, 24'h0};
      else if (int'(nk_m1) == 7 && int'(pos) == 4)    t_word = sub_out;
      new_word = is_key ? key_w[word_cnt[IDX_W-1:0]] : (win[nk_m1] ^ t_word);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_ok) state_nxt = RUN;
         RUN:     if (abort) state_nxt = IDLE;
                  else if (gen_en && word_cnt == last_word) state_nxt = DRAIN;
         DRAIN:   if (abort || hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: clocked blocks use non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_q    <= '0;
         nk_m1    <= '0;
         pos      <= '0;
         word_cnt <= '0;
         rcon     <= 8'h01;
         // NOTE: the window is a handful of flops rather than a RAM, so it takes the async reset too.
         for (int k = 0; k < MAX_NK; k++) win[k] <= '0;
         acc0     <= '0;
         acc1     <= '0;
         acc2     <= '0;
         rk_data  <= '0;
         rk_valid <= 1'b0;
         rk_idx   <= '0;
         rk_last  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         key_err  <= 1'b0;
      end else begin
         done    <= (state == DRAIN) && hs && !abort;
         key_err <= start_bad;
         busy    <= (state_nxt != IDLE);
         if (start_ok) begin
            key_q    <= key_in;
            nk_m1    <= req_nk_m1;
            word_cnt <= '0;
            pos      <= '0;
            rcon     <= 8'h01;
         end
         if (gen_en) begin
            win[0] <= new_word;
            for (int k = 1; k < MAX_NK; k++) win[k] <= win[k-1];
            case (slot)
               2'd0:    acc0 <= new_word;
               2'd1:    acc1 <= new_word;
               2'd2:    acc2 <= new_word;
               default: ;
            endcase
            word_cnt <= word_cnt + 6'd1;
            pos      <= (pos == nk_m1) ? '0 : pos + 1'b1;
            if (!is_key && pos == '0) rcon <= xtime(rcon);
         end
         if (abort && state != IDLE) begin
            rk_valid <= 1'b0;
         end else if (gen_en && slot == 2'd3) begin
            rk_data  <= {acc0, acc1, acc2, new_word};
            rk_valid <= 1'b1;
            rk_idx   <= RK_IDX_W'(word_cnt[5:2]);
            rk_last  <= (word_cnt == last_word);
         end else if (hs) begin
            rk_valid <= 1'b0;
`ifdef AES_KS_ZEROIZE_EN
            rk_data  <= '0;
`endif
         end
`ifdef AES_KS_ZEROIZE_EN
         if (job_end) begin
            key_q   <= '0;
            for (int k = 0; k < MAX_NK; k++) win[k] <= '0;
            acc0    <= '0;
            acc1    <= '0;
            acc2    <= '0;
            rk_data <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_aes_key_schedule_iter.sv
// Scoreboard bench for aes_key_schedule_iter: reference expansion plus known round keys, stalls, abort, reset.
module tb_aes_key_schedule_iter;

   typedef struct {
      logic [127:0] data;
      logic [3:0]   idx;
      logic         last;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   key_len = 2'b00;
   logic [255:0] key_in = '0;
   logic         abort = 1'b0;
   logic         rk_ready = 1'b1;
   logic [127:0] rk_data;
   logic         rk_valid;
   logic [3:0]   rk_idx;
   logic         rk_last;
   logic         busy;
   logic         done;
   logic         key_err;

   beat_t exp_q[$];
   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   int    start_cyc = 0;
   int    exp_lat = 0;
   int    popped = 0;
   int    done_cnt = 0;
   bit    lat_chk = 0;
   bit    rand_ready = 0;
   bit    pend_done = 0;

   localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   aes_key_schedule_iter dut (
      .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in), .abort(abort),
      .rk_data(rk_data), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_idx(rk_idx),
      .rk_last(rk_last), .busy(busy), .done(done), .key_err(key_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] m_sbox(input logic [7:0] x);
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      logic [7:0] c = 8'h63;
      if (x != 0)
         for (int y = 1; y < 256; y++)
            if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
         s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      return s;
   endfunction

   function automatic logic [31:0] m_subword(input logic [31:0] w);
      return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
   endfunction

   // Textbook FIPS-197 expansion of the whole schedule, then one beat per round key.
   task automatic push_job(input int nk, input logic [255:0] key);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rcon = 8'h01;
      int          nr = nk + 6;
      beat_t       b;
      for (int i = 0; i < 4*(nr+1); i++) begin
         if (i < nk) begin
            w[i] = key[255 - 32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t = m_subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
               rcon = m_mul(rcon, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
               t = m_subword(t);
            end
            w[i] = w[i-nk] ^ t;
         end
      end
      for (int r = 0; r <= nr; r++) begin
         b.data = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         b.idx  = 4'(r);
         b.last = (r == nr);
         exp_q.push_back(b);
      end
   endtask

   task automatic pin(input int r, input logic [127:0] d);
      beat_t b = exp_q[r];
      b.data   = d;
      exp_q[r] = b;
   endtask

   task automatic start_job(input logic [1:0] kl, input logic [255:0] k);
      @(posedge clk);
      #1 key_len = kl; key_in = k; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_job(input int max_cyc);
      int n = 0;
      while ((exp_q.size() != 0 || pend_done) && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      if (n >= max_cyc) check("job_timeout", 128'(exp_q.size()), 128'(0));
      check("busy_after_job", busy, 1'b0);
`ifdef AES_KS_ZEROIZE_EN
      check("zeroized_rk_data", rk_data, 128'h0);
`endif
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      #1 rk_ready = rand_ready ? ($urandom_range(0, 99) >= 40) : 1'b1;
   end

   // Scoreboard: every valid cycle compares against the queue head, so stalled data must hold.
   initial forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (pend_done) begin
         check("done_pulse", done, 1'b1);
         pend_done = 0;
      end
      if (rk_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", rk_valid, 1'b0);
         end else begin
            check($sformatf("rk_data[%0d]", exp_q[0].idx), rk_data, exp_q[0].data);
            if (rk_ready) begin
               check("rk_idx", rk_idx, exp_q[0].idx);
               check("rk_last", rk_last, exp_q[0].last);
               if (exp_q[0].last) begin
                  if (lat_chk) check("last_latency", 128'(cyc - start_cyc), 128'(exp_lat));
                  pend_done = 1;
               end
               void'(exp_q.pop_front());
               popped++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n, dc;
      #12;
      check("reset_valid", rk_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_rk_data", rk_data, 128'h0);
      rst = 1'b1;

      // AES-128 with ready held: RK0 after E4, RK10 after E44.
      push_job(4, KEY128);
      pin(0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      pin(1, 128'ha0fafe1788542cb123a339392a6c7605);
      pin(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      lat_chk = 1; exp_lat = 44;
      start_job(2'b00, KEY128);
      check("busy_set", busy, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rk0_not_early", rk_valid, 1'b0);
      @(negedge clk);
      check("rk0_latency", rk_valid, 1'b1);
      wait_job(200);

      push_job(6, KEY192);
      pin(12, 128'ha4970a331a78dc09c418c271e3a41d5d);
      exp_lat = 52;
      start_job(2'b01, KEY192);
      wait_job(200);

      push_job(8, KEY256);
      pin(14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
      exp_lat = 60;
      start_job(2'b10, KEY256);
      wait_job(200);

      // Random backpressure.
      lat_chk = 0; rand_ready = 1;
      push_job(4, KEY128);
      pin(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      start_job(2'b00, KEY128);
      wait_job(1000);
      rand_ready = 0;

      // Illegal key length.
      @(posedge clk);
      #1 key_len = 2'b11; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("key_err_pulse", key_err, 1'b1);
      check("key_err_busy", busy, 1'b0);
      @(negedge clk);
      check("key_err_one_cycle", key_err, 1'b0);
      check("key_err_idle", busy, 1'b0);

      // Start while busy is ignored; abort after RK3 gives no done.
      push_job(4, KEY128);
      base = popped;
      start_job(2'b00, KEY128);
      repeat (4) @(posedge clk);
      #1 key_len = 2'b10; key_in = KEY256; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("busy_start_no_err", key_err, 1'b0);
      check("busy_start_busy", busy, 1'b1);
      n = 0;
      while (popped < base + 4 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (n >= 100) check("abort_wait_timeout", 128'(popped - base), 128'(4));
      #1 abort = 1'b1;
      dc = done_cnt;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 1'b0);
      check("abort_valid", rk_valid, 1'b0);
      exp_q.delete();
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("abort_no_done", 128'(done_cnt), 128'(dc));

      push_job(4, KEY128);
      pin(1, 128'ha0fafe1788542cb123a339392a6c7605);
      pin(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      start_job(2'b00, KEY128);
      wait_job(200);

      // Asynchronous reset in the middle of a job.
      push_job(8, KEY256);
      start_job(2'b10, KEY256);
      repeat (20) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("arst_valid", rk_valid, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_rk_data", rk_data, 128'h0);
      check("arst_rk_idx", rk_idx, 4'h0);
      check("arst_rk_last", rk_last, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_key_err", key_err, 1'b0);
      exp_q.delete();
      pend_done = 0;
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("post_arst_idle", busy, 1'b0);
      check("post_arst_no_valid", rk_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
